// File: rtl/uart_port_tx.sv
// Byte-wide CPU output port feeding an 8N1 UART transmitter through a small FIFO.
// The status byte is combinational from registers so the CPU sees state right after each edge.
module uart_port_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       write_strobe,
    input  logic       clear_ovf,
    output logic       tx,
    output logic [7:0] status
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [7:0]    BAUD_LAST  = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [7:0]    baud_cnt;
    logic          overflow;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic bit_end;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // Fullness is judged before any pop on the same edge, so a write into a full FIFO is always lost.
    assign push    = write_strobe && !full;
    assign pop     = (state == IDLE) && !empty;
    assign bit_end = (baud_cnt == BAUD_LAST);

    assign status = {4'b0000, overflow, empty, full, (state != IDLE) || !empty};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A fresh overflow wins over a simultaneous clear.
            if (write_strobe && full) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shreg    <= mem[head];
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Shift right so the next bit to send always sits at shreg[1] beforehand.
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
